// File: rtl/multi_agent_driver.sv
// Multi-channel counter-stream driver with burst round-robin arbitration.
// One valid/ready output; per-channel accepted-beat counters exposed.
module multi_agent_driver #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter int BURST_LEN = 4,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_last,
  output logic [NUM_CH*CNT_W-1:0] ch_count,
  output logic                    busy
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0] gen_q [NUM_CH];
  logic [DATA_W-1:0] gen_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  logic            grant_vld;
  logic [CH_W-1:0] grant_ch;
  logic            is_last;

  assign is_last = (beat_q == BEAT_W'(BURST_LEN - 1));

  // Cyclic search starting just after the last granted channel
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_q) + k) % NUM_CH;
      if (!grant_vld && ch_en[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ch_d    = ch_q;
    last_d  = last_q;
    gen_d   = gen_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (en && grant_vld) begin
          state_d = S_BURST;
          beat_d  = '0;
          ch_d    = grant_ch;
          last_d  = grant_ch;
        end
      end
      default: begin
        if (out_ready) begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == CH_W'(c)) begin
              gen_d[c] = gen_q[c] + 1'b1;
              cnt_d[c] = cnt_q[c] + 1'b1;
            end
          end
          if (is_last) state_d = S_IDLE;
          else beat_d = beat_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      ch_q    <= '0;
      last_q  <= CH_W'(NUM_CH - 1);
      for (int c = 0; c < NUM_CH; c++) begin
        gen_q[c] <= DATA_W'(c * 16);
        cnt_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      gen_q   <= gen_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == S_BURST);
  assign out_valid = busy;
  assign out_last  = busy && is_last;
  assign out_ch    = ch_q;

  always_comb begin
    out_data = '0;
    ch_count = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (busy && ch_q == CH_W'(c)) out_data = gen_q[c];
      ch_count[c*CNT_W +: CNT_W] = cnt_q[c];
    end
  end

endmodule

// File: tb/tb_multi_agent_driver.sv
// Bench for multi_agent_driver: vector table, corner sequences,
// and randomized traffic against a transaction-level model.
module tb_multi_agent_driver;

  localparam int NCH = 2;
  localparam int BL  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  ch_en;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [0:0]  out_ch;
  logic        out_last;
  logic [15:0] ch_count;
  logic        busy;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  multi_agent_driver #(
    .NUM_CH(NCH), .DATA_W(8), .CNT_W(8), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ch_en(ch_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .ch_count(ch_count),
    .busy(busy)
  );

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic drv(logic r, logic e, logic [1:0] ce,
                     logic rd);
    rst = r; en = e; ch_en = ce; out_ready = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] snap();
    return {out_valid, out_data, out_ch, out_last, busy,
            ch_count};
  endfunction

  // Transaction-level model: bursts of BL beats, counters as ints
  int m_gen [NCH];
  int m_cnt [NCH];
  bit m_busy;
  int m_beats_left;
  int m_cur;
  int m_last;

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_gen[c] = (c * 16) % 256;
      m_cnt[c] = 0;
    end
    m_busy = 0;
    m_beats_left = 0;
    m_cur = 0;
    m_last = NCH - 1;
  endtask

  task automatic m_step(bit r, bit e, logic [1:0] ce, bit rd);
    bit found;
    found = 0;
    if (r) begin
      m_reset();
    end else if (!m_busy) begin
      if (e) begin
        for (int k = 1; k <= NCH; k++) begin
          int c;
          c = (m_last + k) % NCH;
          if (!found && ce[c]) begin
            found = 1;
            m_cur = c;
            m_last = c;
          end
        end
        if (found) begin
          m_busy = 1;
          m_beats_left = BL;
        end
      end
    end else if (rd) begin
      m_gen[m_cur] = (m_gen[m_cur] + 1) % 256;
      m_cnt[m_cur] = (m_cnt[m_cur] + 1) % 256;
      m_beats_left--;
      if (m_beats_left == 0) m_busy = 0;
    end
  endtask

  function automatic logic [27:0] m_exp();
    logic [7:0] d;
    d = m_busy ? 8'(m_gen[m_cur]) : 8'h00;
    return {m_busy, d, 1'(m_cur),
            m_busy && (m_beats_left == 1), m_busy,
            8'(m_cnt[1]), 8'(m_cnt[0])};
  endfunction

  typedef struct {
    logic        r;
    logic        e;
    logic [1:0]  ce;
    logic        rd;
    logic        v;
    logic [7:0]  d;
    logic        c;
    logic        l;
    logic        b;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(logic r, logic v, logic [7:0] d,
                              logic c, logic l,
                              logic [15:0] cnt);
    vec_t t;
    t.r = r; t.e = 1'b1; t.ce = 2'b11; t.rd = 1'b1;
    t.v = v; t.d = d; t.c = c; t.l = l; t.b = v;
    t.cnt = cnt;
    return t;
  endfunction

  logic [7:0] wlog [256];
  logic [8:0] q4 [$];

  initial begin
    int n;
    int nv;
    logic [7:0] c255;
    logic [1:0] rce;
    logic rr, re, rrd;

    vecs[0]  = mk(1, 0, 8'h00, 0, 0, 16'h0000);
    vecs[1]  = mk(1, 0, 8'h00, 0, 0, 16'h0000);
    vecs[2]  = mk(0, 1, 8'h00, 0, 0, 16'h0000);
    vecs[3]  = mk(0, 1, 8'h01, 0, 0, 16'h0001);
    vecs[4]  = mk(0, 1, 8'h02, 0, 0, 16'h0002);
    vecs[5]  = mk(0, 1, 8'h03, 0, 1, 16'h0003);
    vecs[6]  = mk(0, 0, 8'h00, 0, 0, 16'h0004);
    vecs[7]  = mk(0, 1, 8'h10, 1, 0, 16'h0004);
    vecs[8]  = mk(0, 1, 8'h11, 1, 0, 16'h0104);
    vecs[9]  = mk(0, 1, 8'h12, 1, 0, 16'h0204);
    vecs[10] = mk(0, 1, 8'h13, 1, 1, 16'h0304);
    vecs[11] = mk(0, 0, 8'h00, 1, 0, 16'h0404);
    vecs[12] = mk(0, 1, 8'h04, 0, 0, 16'h0404);
    vecs[13] = mk(0, 1, 8'h05, 0, 0, 16'h0405);
    vecs[14] = mk(0, 1, 8'h06, 0, 0, 16'h0406);
    vecs[15] = mk(0, 1, 8'h07, 0, 1, 16'h0407);
    vecs[16] = mk(0, 0, 8'h00, 0, 0, 16'h0408);

    drv(1, 1, 2'b11, 1);
    for (int i = 0; i < 17; i++) begin
      drv(vecs[i].r, vecs[i].e, vecs[i].ce, vecs[i].rd);
      tick();
      check($sformatf("vec%0d", i), 32'(snap()),
            32'({vecs[i].v, vecs[i].d, vecs[i].c,
                 vecs[i].l, vecs[i].b, vecs[i].cnt}));
    end

    // Backpressure on beat 0x02
    drv(1, 1, 2'b11, 1); tick();
    rst = 0;
    tick(); tick(); tick();
    check("bp_first", 32'(out_data), 32'h02);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i),
            32'({out_valid, out_data, out_ch, out_last}),
            32'({1'b1, 8'h02, 1'b0, 1'b0}));
    end
    out_ready = 1;
    tick();
    check("bp_next", 32'({out_data, out_last}),
          32'({8'h03, 1'b1}));
    tick();
    check("bp_cnt", 32'(ch_count), 32'h0004);

    // Single-channel request, back-to-back bursts
    drv(1, 1, 2'b10, 1); tick();
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) q4.push_back({out_ch, out_data});
    end
    check("ch1_beats", 32'(q4.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ch1_beat%0d", i),
            32'(q4.size() > i ? q4[i] : 9'h0),
            32'({1'b1, 8'(8'h10 + i)}));
    end
    tick();
    check("dis_first", 32'({out_valid, out_data}),
          32'({1'b1, 8'h18}));
    ch_en = 2'b00;
    nv = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) nv++;
    end
    check("dis_beats", 32'(nv), 32'd4);
    check("dis_idle", 32'({out_valid, busy}), 32'h0);

    // Reset in the middle of a burst
    drv(1, 1, 2'b11, 1); tick();
    rst = 0;
    tick(); tick(); tick();
    check("mr_at02", 32'(out_data), 32'h02);
    rst = 1;
    tick();
    rst = 0;
    check("mr_after", 32'({out_valid, busy, ch_count}),
          32'h0);
    tick();
    check("mr_regrant",
          32'({out_valid, out_ch, out_data}),
          32'({1'b1, 1'b0, 8'h00}));

    // Wrap-around on channel 1
    drv(1, 1, 2'b10, 1); tick();
    rst = 0;
    n = 0;
    c255 = 8'h00;
    for (int cyc = 0; cyc < 600 && n < 256; cyc++) begin
      tick();
      if (out_valid) begin
        if (n == 255) c255 = ch_count[15:8];
        wlog[n] = out_data;
        n++;
      end
    end
    check("wrap_n", 32'(n), 32'd256);
    tick();
    check("wrap_b240", 32'(wlog[239]), 32'hFF);
    check("wrap_b241", 32'(wlog[240]), 32'h00);
    check("wrap_b256", 32'(wlog[255]), 32'h0F);
    check("wrap_c255", 32'(c255), 32'd255);
    check("wrap_c0", 32'(ch_count), 32'h0000);

    // Randomized traffic against the model
    drv(1, 1, 2'b11, 1); tick();
    m_reset();
    for (int i = 0; i < 1500; i++) begin
      rr  = ($urandom_range(63) == 0);
      re  = ($urandom_range(7) != 0);
      rce = 2'($urandom);
      rrd = ($urandom_range(3) != 0);
      drv(rr, re, rce, rrd);
      m_step(rr, re, rce, rrd);
      tick();
      check($sformatf("rand%0d", i), 32'(snap()),
            32'(m_exp()));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
